// File: rtl/sm83_seq_pkg.sv
// Shared constants, flag bundle and one-hot decode helper for the SM83 cycle sequencer.
package sm83_seq_pkg;

  localparam int T_PER_M_DEF = 4;
  localparam int M_MAX_DEF   = 6;
  localparam int IDX_VEC_W   = 16;

  typedef struct packed {
    logic m_ovf;
    logic seq_err;
  } seq_flags_t;

  // Vectors narrower than IDX_VEC_W are zero-extended by the caller.
  function automatic logic [3:0] onehot_to_idx(input logic [IDX_VEC_W-1:0] vec);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < IDX_VEC_W; i++) begin
      if (vec[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sm83_onehot_ring.sv
// One-hot rotating register: load-first beats hold beats advance; optional saturation at the top bit.
// Registered output, one clock from control to new position.
module sm83_onehot_ring #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load_first,
  input  logic             i_hold,
  input  logic             i_advance,
  input  logic             i_sat_en,
  output logic [WIDTH-1:0] o_vec
);

  logic [WIDTH-1:0] r_vec;
  logic [WIDTH-1:0] w_vec_nxt;
  logic [WIDTH-1:0] w_first;

  assign w_first = WIDTH'(1);
  assign o_vec   = r_vec;

  always_comb begin
    w_vec_nxt = r_vec;
    if (i_load_first) begin
      w_vec_nxt = w_first;
    end else if (i_hold) begin
      w_vec_nxt = r_vec;
    end else if (i_advance) begin
      if (i_sat_en && r_vec[WIDTH-1]) w_vec_nxt = r_vec;
      else                            w_vec_nxt = {r_vec[WIDTH-2:0], r_vec[WIDTH-1]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_vec <= w_first;
    else         r_vec <= w_vec_nxt;
  end

endmodule

// File: rtl/sm83_cycle_sequencer.sv
// SM83 T-state / M-cycle strobe generator with stall, resync, saturation and misuse flags.
// Optional completed-M-cycle counter port o_mcount when SM83_SEQ_MCOUNT_EN is defined.
module sm83_cycle_sequencer
  import sm83_seq_pkg::*;
#(
  parameter int T_PER_M  = T_PER_M_DEF,
  parameter int M_MAX    = M_MAX_DEF,
  parameter int MCOUNT_W = 16
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_ncyc,
  input  logic                       i_set_m1,
  input  logic                       i_stall,
  output logic [T_PER_M-1:0]         o_t,
  output logic [M_MAX-1:0]           o_m,
  output logic [$clog2(M_MAX)-1:0]   o_m_idx,
  output logic                       o_t_last,
  output logic                       o_m_boundary,
  output logic                       o_m_ovf,
  output logic                       o_seq_err
`ifdef SM83_SEQ_MCOUNT_EN
  ,
  output logic [MCOUNT_W-1:0]        o_mcount
`endif
);

  localparam int MIDX_W = $clog2(M_MAX);

  if (T_PER_M < 2 || T_PER_M > 8 || M_MAX < 2 || M_MAX > 16 || MCOUNT_W < 1) begin : g_bad_params
    $error("sm83_cycle_sequencer: parameter out of legal range");
  end

  logic                 w_m_adv;
  logic [IDX_VEC_W-1:0] w_m_wide;
  logic [3:0]           w_m_idx4;
  seq_flags_t           r_flags;

  assign o_t_last     = o_t[T_PER_M-1];
  assign o_m_boundary = o_t_last & ~i_stall;
  // A resync on the last T-state restarts the cycle instead of completing it.
  assign w_m_adv      = o_m_boundary & ~i_ncyc;

  sm83_onehot_ring #(.WIDTH(T_PER_M)) u_t_ring (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_load_first (i_ncyc),
    .i_hold       (i_stall),
    .i_advance    (1'b1),
    .i_sat_en     (1'b0),
    .o_vec        (o_t)
  );

  sm83_onehot_ring #(.WIDTH(M_MAX)) u_m_ring (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_load_first (w_m_adv & i_set_m1),
    .i_hold       (~w_m_adv),
    .i_advance    (w_m_adv),
    .i_sat_en     (1'b1),
    .o_vec        (o_m)
  );

  assign w_m_wide = IDX_VEC_W'(o_m);
  assign w_m_idx4 = onehot_to_idx(w_m_wide);
  assign o_m_idx  = w_m_idx4[MIDX_W-1:0];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_flags <= '0;
    end else begin
      if (w_m_adv && !i_set_m1 && o_m[M_MAX-1]) r_flags.m_ovf <= 1'b1;
      if (i_set_m1 && !o_t_last)                r_flags.seq_err <= 1'b1;
    end
  end

  assign o_m_ovf   = r_flags.m_ovf;
  assign o_seq_err = r_flags.seq_err;

`ifdef SM83_SEQ_MCOUNT_EN
  logic [MCOUNT_W-1:0] r_mcount;

  always_ff @(posedge i_clk) begin
    if (i_reset)      r_mcount <= '0;
    else if (w_m_adv) r_mcount <= r_mcount + MCOUNT_W'(1);
  end

  assign o_mcount = r_mcount;
`endif

endmodule

// File: tb/tb_sm83_cycle_sequencer.sv
// Directed self-checking bench for sm83_cycle_sequencer (default 4T/6M instance plus a 3T/2M instance).
module tb_sm83_cycle_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ncyc = 1'b0;
  logic set_m1 = 1'b0;
  logic stall = 1'b0;
  logic reset2 = 1'b1;

  logic [3:0]  t;
  logic [5:0]  m;
  logic [2:0]  m_idx;
  logic        t_last, m_boundary, m_ovf, seq_err;
  logic [2:0]  t2;
  logic [1:0]  m2;
  logic [0:0]  m_idx2;
  logic        t_last2, m_boundary2, m_ovf2, seq_err2;
`ifdef SM83_SEQ_MCOUNT_EN
  logic [15:0] mcount;
  logic [15:0] mcount2;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sm83_cycle_sequencer dut (
    .i_clk(clk), .i_reset(reset), .i_ncyc(ncyc), .i_set_m1(set_m1), .i_stall(stall),
    .o_t(t), .o_m(m), .o_m_idx(m_idx), .o_t_last(t_last), .o_m_boundary(m_boundary),
    .o_m_ovf(m_ovf), .o_seq_err(seq_err)
`ifdef SM83_SEQ_MCOUNT_EN
    , .o_mcount(mcount)
`endif
  );

  sm83_cycle_sequencer #(.T_PER_M(3), .M_MAX(2)) dut2 (
    .i_clk(clk), .i_reset(reset2), .i_ncyc(1'b0), .i_set_m1(1'b0), .i_stall(1'b0),
    .o_t(t2), .o_m(m2), .o_m_idx(m_idx2), .o_t_last(t_last2), .o_m_boundary(m_boundary2),
    .o_m_ovf(m_ovf2), .o_seq_err(seq_err2)
`ifdef SM83_SEQ_MCOUNT_EN
    , .o_mcount(mcount2)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; ncyc = 1'b0; set_m1 = 1'b0; stall = 1'b0;
    ticks(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (t !== 4'b0001)   begin failures++; $display("FAIL reset_t got=%b exp=0001", t); end
    checks++; if (m !== 6'b000001) begin failures++; $display("FAIL reset_m got=%b exp=000001", m); end
    checks++; if (m_idx !== 3'd0)  begin failures++; $display("FAIL reset_m_idx got=%0d exp=0", m_idx); end
    checks++; if ({m_ovf, seq_err} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {m_ovf, seq_err}); end
`ifdef SM83_SEQ_MCOUNT_EN
    checks++; if (mcount !== 16'd0) begin failures++; $display("FAIL reset_mcount got=%0d exp=0", mcount); end
`endif
  endtask

  task automatic test_free_run();
    logic [3:0] exp_t;
    logic [5:0] exp_m;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      exp_t = 4'b0001 << (i % 4);
      exp_m = 6'b000001 << (i / 4);
      checks++; if (t !== exp_t) begin failures++; $display("FAIL run_t cyc=%0d got=%b exp=%b", i, t, exp_t); end
      checks++; if (m !== exp_m) begin failures++; $display("FAIL run_m cyc=%0d got=%b exp=%b", i, m, exp_m); end
      if (i < 11) tick();
    end
    checks++; if (m_idx !== 3'd2) begin failures++; $display("FAIL run_m_idx got=%0d exp=2", m_idx); end
    checks++; if (t_last !== 1'b1) begin failures++; $display("FAIL run_t_last got=%b exp=1", t_last); end
    checks++; if ({m_ovf, seq_err} !== 2'b00) begin failures++; $display("FAIL run_flags got=%b exp=00", {m_ovf, seq_err}); end
  endtask

  task automatic test_stall();
    do_reset();
    ticks(5);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (t !== 4'b0010 || m !== 6'b000010) begin
        failures++; $display("FAIL stall_hold cyc=%0d got t=%b m=%b exp t=0010 m=000010", i, t, m);
      end
    end
    stall = 1'b0;
    tick();
    checks++; if (t !== 4'b0100) begin failures++; $display("FAIL stall_resume_t got=%b exp=0100", t); end
    tick();
    stall = 1'b1;
    #1;
    checks++; if (m_boundary !== 1'b0) begin failures++; $display("FAIL stall_boundary_low got=%b exp=0", m_boundary); end
`ifdef SM83_SEQ_MCOUNT_EN
    checks++; if (mcount !== 16'd1) begin failures++; $display("FAIL stall_mcount_late got=%0d exp=1", mcount); end
`endif
    tick();
    checks++; if (t !== 4'b1000 || m !== 6'b000010) begin
      failures++; $display("FAIL stall_at_last got t=%b m=%b exp t=1000 m=000010", t, m);
    end
    stall = 1'b0;
    #1;
    checks++; if (m_boundary !== 1'b1) begin failures++; $display("FAIL stall_boundary_high got=%b exp=1", m_boundary); end
    tick();
    checks++; if (t !== 4'b0001 || m !== 6'b000100) begin
      failures++; $display("FAIL stall_advance got t=%b m=%b exp t=0001 m=000100", t, m);
    end
`ifdef SM83_SEQ_MCOUNT_EN
    checks++; if (mcount !== 16'd2) begin failures++; $display("FAIL stall_mcount got=%0d exp=2", mcount); end
`endif
  endtask

  task automatic test_set_m1();
    do_reset();
    ticks(11);
    set_m1 = 1'b1;
    tick();
    set_m1 = 1'b0;
    checks++; if (t !== 4'b0001 || m !== 6'b000001) begin
      failures++; $display("FAIL setm1_boundary got t=%b m=%b exp t=0001 m=000001", t, m);
    end
    checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL setm1_legal_err got=%b exp=0", seq_err); end
    ticks(5);
    set_m1 = 1'b1;
    tick();
    set_m1 = 1'b0;
    checks++; if (t !== 4'b0100 || m !== 6'b000010) begin
      failures++; $display("FAIL setm1_illegal got t=%b m=%b exp t=0100 m=000010", t, m);
    end
    checks++; if (seq_err !== 1'b1) begin failures++; $display("FAIL setm1_seq_err got=%b exp=1", seq_err); end
    tick();
    stall = 1'b1; set_m1 = 1'b1;
    tick();
    stall = 1'b0; set_m1 = 1'b0;
    tick();
    checks++; if (m !== 6'b000100 || m_idx !== 3'd2) begin
      failures++; $display("FAIL setm1_deferred_dropped got m=%b idx=%0d exp m=000100 idx=2", m, m_idx);
    end
    checks++; if (seq_err !== 1'b1) begin failures++; $display("FAIL setm1_err_sticky got=%b exp=1", seq_err); end
  endtask

  task automatic test_saturate();
    logic [2:0] exp_t;
    logic [1:0] exp_m;
    reset2 = 1'b1;
    ticks(2);
    reset2 = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_t = 3'b001 << (k % 3);
      exp_m = (k >= 3) ? 2'b10 : 2'b01;
      checks++; if (t2 !== exp_t || m2 !== exp_m) begin
        failures++; $display("FAIL sat_tm clk=%0d got t=%b m=%b exp t=%b m=%b", k, t2, m2, exp_t, exp_m);
      end
      checks++; if (m_ovf2 !== (k >= 6)) begin
        failures++; $display("FAIL sat_ovf clk=%0d got=%b exp=%b", k, m_ovf2, (k >= 6));
      end
    end
    checks++; if (m_idx2 !== 1'b1) begin failures++; $display("FAIL sat_m_idx got=%0d exp=1", m_idx2); end
`ifdef SM83_SEQ_MCOUNT_EN
    checks++; if (mcount2 !== 16'd3) begin failures++; $display("FAIL sat_mcount got=%0d exp=3", mcount2); end
`endif
  endtask

  task automatic test_ncyc();
    do_reset();
    ticks(2);
    ncyc = 1'b1;
    tick();
    ncyc = 1'b0;
    checks++; if (t !== 4'b0001 || m !== 6'b000001) begin
      failures++; $display("FAIL ncyc_t3 got t=%b m=%b exp t=0001 m=000001", t, m);
    end
    ticks(3);
    ncyc = 1'b1;
    tick();
    ncyc = 1'b0;
    checks++; if (t !== 4'b0001 || m !== 6'b000001) begin
      failures++; $display("FAIL ncyc_t4 got t=%b m=%b exp t=0001 m=000001", t, m);
    end
`ifdef SM83_SEQ_MCOUNT_EN
    checks++; if (mcount !== 16'd0) begin failures++; $display("FAIL ncyc_mcount got=%0d exp=0", mcount); end
`endif
    tick();
    ncyc = 1'b1; stall = 1'b1;
    tick();
    ncyc = 1'b0; stall = 1'b0;
    checks++; if (t !== 4'b0001) begin failures++; $display("FAIL ncyc_over_stall got=%b exp=0001", t); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    tick();
    set_m1 = 1'b1;
    tick();
    set_m1 = 1'b0;
    ticks(11);
    checks++; if (t !== 4'b0010 || m !== 6'b001000 || seq_err !== 1'b1) begin
      failures++; $display("FAIL rst_setup got t=%b m=%b err=%b exp t=0010 m=001000 err=1", t, m, seq_err);
    end
    stall = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    checks++; if (t !== 4'b0001 || m !== 6'b000001 || {m_ovf, seq_err} !== 2'b00) begin
      failures++; $display("FAIL rst_mid got t=%b m=%b flags=%b exp t=0001 m=000001 flags=00", t, m, {m_ovf, seq_err});
    end
`ifdef SM83_SEQ_MCOUNT_EN
    checks++; if (mcount !== 16'd0) begin failures++; $display("FAIL rst_mid_mcount got=%0d exp=0", mcount); end
`endif
    reset = 1'b0; stall = 1'b0;
    tick();
    checks++; if (t !== 4'b0010 || m !== 6'b000001) begin
      failures++; $display("FAIL rst_release got t=%b m=%b exp t=0010 m=000001", t, m);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_set_m1();
    test_saturate();
    test_ncyc();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
